// File: rtl/dpa_tap_scan_ctrl.sv
// Dynamic-phase-alignment tap scan: sweeps the master tap 0..63, finds the widest stable
// data window and parks the master tap at its centre with the slave tap at a fixed offset.
module dpa_tap_scan_ctrl #(
  parameter int unsigned SETTLE_CYC   = 4,
  parameter int unsigned SAMPLE_CYC   = 8,
  parameter int unsigned SLAVE_OFFSET = 11,
  parameter int unsigned MIN_WIN      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] M_data_In,
  input  logic [7:0] S_data_In,
  output logic [5:0] M_delay_val_Out,
  output logic [5:0] S_delay_val_Out,
  output logic       busy,
  output logic       done,
  output logic       locked,
  output logic       fail,
  output logic [5:0] win_start,
  output logic [6:0] win_len,
  output logic [7:0] lock_word_m,
  output logic [7:0] lock_word_s
);

  typedef enum logic [3:0] {
    StIdle, StSet, StSettle, StSample, StEval, StCenter, StVsettle, StVerify, StFin
  } state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] SampleLast = 4'(SAMPLE_CYC - 1);
  localparam logic [6:0] SlaveOff   = 7'(SLAVE_OFFSET);
  localparam logic [6:0] MinWin     = 7'(MIN_WIN);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] m_tap_q, m_tap_d, s_tap_q, s_tap_d;
  logic [7:0] ref_q, ref_d, prev_q, prev_d;
  logic       unstable_q, unstable_d;
  logic       run_open_q, run_open_d;
  logic [5:0] run_start_q, run_start_d, best_start_q, best_start_d, win_start_q, win_start_d;
  logic [6:0] run_len_q, run_len_d, best_len_q, best_len_d, win_len_q, win_len_d;
  logic [7:0] lock_m_q, lock_m_d, lock_s_q, lock_s_d;
  logic       locked_q, locked_d, fail_q, fail_d;

  logic       good, close_run;
  logic [5:0] close_start;
  logic [6:0] close_len, center, s_sum;

  // Window centre and saturated slave tap, computed in 7 bits so the sum never wraps.
  assign center = {1'b0, best_start_q} + ((best_len_q - 7'd1) >> 1);
  assign s_sum  = center + SlaveOff;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    m_tap_d      = m_tap_q;
    s_tap_d      = s_tap_q;
    ref_d        = ref_q;
    prev_d       = prev_q;
    unstable_d   = unstable_q;
    run_open_d   = run_open_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    win_start_d  = win_start_q;
    win_len_d    = win_len_q;
    lock_m_d     = lock_m_q;
    lock_s_d     = lock_s_q;
    locked_d     = locked_q;
    fail_d       = fail_q;
    done         = 1'b0;
    good         = 1'b0;
    close_run    = 1'b0;
    close_start  = '0;
    close_len    = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StSet;
          locked_d     = 1'b0;
          fail_d       = 1'b0;
          best_start_d = '0;
          best_len_d   = '0;
          run_open_d   = 1'b0;
          run_start_d  = '0;
          run_len_d    = '0;
          win_start_d  = '0;
          win_len_d    = '0;
          m_tap_d      = '0;
          s_tap_d      = '0;
        end
      end
      StSet: begin
        cnt_d      = '0;
        unstable_d = 1'b0;
        state_d    = StSettle;
      end
      StSettle, StVsettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = (state_q == StSettle) ? StSample : StVerify;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        if (cnt_q == '0) ref_d = M_data_In;
        else if (M_data_In != ref_q) unstable_d = 1'b1;
        if (cnt_q == SampleLast) state_d = StEval;
        else cnt_d = cnt_q + 4'd1;
      end
      StEval: begin
        prev_d = ref_q;
        good   = !unstable_q && ((m_tap_q == 6'd0) || (ref_q == prev_q));
        if (good) begin
          if (run_open_q) begin
            run_len_d = run_len_q + 7'd1;
          end else begin
            run_open_d  = 1'b1;
            run_start_d = m_tap_q;
            run_len_d   = 7'd1;
          end
          // A run still open at the last tap must close here.
          if (m_tap_q == 6'd63) begin
            close_run   = 1'b1;
            close_start = run_open_q ? run_start_q : m_tap_q;
            close_len   = run_len_d;
            run_open_d  = 1'b0;
          end
        end else if (run_open_q) begin
          close_run   = 1'b1;
          close_start = run_start_q;
          close_len   = run_len_q;
          run_open_d  = 1'b0;
        end
        if (close_run && (close_len > best_len_q)) begin
          best_start_d = close_start;
          best_len_d   = close_len;
        end
        if (m_tap_q == 6'd63) begin
          state_d = StCenter;
        end else begin
          m_tap_d = m_tap_q + 6'd1;
          s_tap_d = m_tap_q + 6'd1;
          state_d = StSet;
        end
      end
      StCenter: begin
        win_start_d = best_start_q;
        win_len_d   = best_len_q;
        if (best_len_q < MinWin) begin
          fail_d  = 1'b1;
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          m_tap_d = center[5:0];
          s_tap_d = (s_sum > 7'd63) ? 6'd63 : s_sum[5:0];
          cnt_d   = '0;
          state_d = StVsettle;
        end
      end
      StVerify: begin
        if (cnt_q == '0) begin
          lock_m_d = M_data_In;
          lock_s_d = S_data_In;
        end else if (M_data_In != lock_m_q) begin
          fail_d = 1'b1;
        end
        if (cnt_q == SampleLast) state_d = StFin;
        else cnt_d = cnt_q + 4'd1;
      end
      StFin: begin
        done     = 1'b1;
        locked_d = !fail_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      m_tap_q      <= '0;
      s_tap_q      <= '0;
      ref_q        <= '0;
      prev_q       <= '0;
      unstable_q   <= 1'b0;
      run_open_q   <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      win_start_q  <= '0;
      win_len_q    <= '0;
      lock_m_q     <= '0;
      lock_s_q     <= '0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      m_tap_q      <= m_tap_d;
      s_tap_q      <= s_tap_d;
      ref_q        <= ref_d;
      prev_q       <= prev_d;
      unstable_q   <= unstable_d;
      run_open_q   <= run_open_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      win_start_q  <= win_start_d;
      win_len_q    <= win_len_d;
      lock_m_q     <= lock_m_d;
      lock_s_q     <= lock_s_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  assign M_delay_val_Out = m_tap_q;
  assign S_delay_val_Out = s_tap_q;
  assign busy            = (state_q != StIdle);
  assign locked          = locked_q;
  assign fail            = fail_q;
  assign win_start       = win_start_q;
  assign win_len         = win_len_q;
  assign lock_word_m     = lock_m_q;
  assign lock_word_s     = lock_s_q;

endmodule
